id_stage: RTL
=============

# id_stage

Instruction-decode stage of the 5-stage pipeline, between the IF/ID register and the EX stage, and the direct consumer of the register file's read ports. It decodes the RV32I instruction and drives the register-file read addresses. It resolves operands through EX/MEM/WB bypasses, detects load-use hazards and inserts bubbles. Results are held in the ID/EX pipeline register, with a valid/ready handshake on both sides.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- reset  in  1  reset is synchronous and active-high
- if_valid  in  1  IF/ID holds an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction PC
- if_ready  out  1  ID consumes the IF/ID instruction this cycle
- rf_read_addr_1 / rf_read_addr_2  out  5  rs1 / rs2 fields, driven combinationally
- rf_read_data_1 / rf_read_data_2  in  32  combinational register-file read data
- ex_reg_write, ex_is_load  in  1  instruction in EX writes rd / is a load
- ex_rd  in  5, ex_result  in  32  EX destination register and ALU result
- mem_reg_write  in  1, mem_rd  in  5, mem_result  in  32  MEM-stage writeback value, load data included
- wb_reg_write  in  1, wb_rd  in  5, wb_data  in  32  value the register file writes this cycle
- flush  in  1  branch/jump taken in EX; kill the ID instruction
- ex_ready  in  1  EX accepts ID/EX this cycle
- id_valid  out  1  ID/EX holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  out  32 each  registered PC, operands, sign-extended immediate
- id_rd  out  5, id_opcode  out  7, id_funct3  out  3, id_funct7b5  out  1  registered decode fields
- id_reg_write, id_is_load, id_is_store  out  1 each  registered control bits

## Operation
- Decode: the opcode sets uses_rs1, uses_rs2, reg_write, is_load, is_store and the immediate format (I/S/B/U/J).
  - LUI, AUIPC and JAL do not use rs1. Only R, S and B types use rs2.
  - reg_write is forced to 0 when rd == 0.
- Immediate generation follows the RV32I bit layout, sign-extended from instr[31]. U-type is instr[31:12] followed by 12 zeros. Unknown opcodes give imm = 0, reg_write = 0 and is a NOP.
- Operand select, per source: the x0 source gives 0. Otherwise the first match in this priority order wins:
  1. EX: ex_reg_write && !ex_is_load && ex_rd == rs
  2. MEM: mem_reg_write && mem_rd == rs
  3. WB: wb_reg_write && wb_rd == rs
  4. Register-file data

  WB bypass is mandatory because the register-file write lands only at the clock edge.
- Load-use hazard: if_valid && ex_is_load && ex_reg_write && ex_rd != 0 && ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2)).
- if_ready = flush || (ex_ready && !hazard).

## Timing
- Decode and operand select are combinational, with zero-cycle RF read. ID/EX latency is 1 cycle.
- Reset: every ID/EX output register is 0, including id_valid = 0. Reset wins over every other input and kills any in-flight instruction.
- ID/EX update at the clock edge, with the first matching rule applied:
  1. flush: id_valid <= 0; the IF/ID instruction is discarded (if_ready = 1).
  2. !ex_ready: all ID/EX registers hold; if_ready = 0.
  3. hazard: bubble, with id_valid <= 0 and id_reg_write/id_is_load/id_is_store <= 0; IF/ID held (if_ready = 0). The instruction is re-decoded next cycle, when the load is in MEM and is forwarded from mem_result.
  4. Otherwise: load the decoded fields; id_valid <= if_valid.
- A load-use hazard costs exactly 1 bubble. Back-to-back independent instructions issue one per cycle.
- Flush and hazard in the same cycle: flush wins and no stall cycle is spent.
- When id_valid = 0, downstream ignores the payload fields.

## Structure
- The shared package riscv_pkg holds:
  - opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG
  - the immediate-format enum imm_fmt_t
  - XLEN
- One combinational sub-module, imm_gen: (instr, imm_fmt_t) -> 32-bit immediate.
- Hazard/forward logic and the ID/EX register stay in id_stage.

## Test plan
- Reset then idle: after reset id_valid = 0 and every output is 0. Feed addi x1,x0,5 (0x00500093) with if_valid = 1 and ex_ready = 1. Next cycle: id_valid = 1, id_imm = 5, id_rd = 1, id_reg_write = 1, rf_read_addr_1 = 0, id_rs1_data = 0.
- Forward priority: rs1 = x3 matches EX (ex_result = 0xA), MEM (0xB) and WB (0xC), with RF returning 0xD.
  - id_rs1_data = 0xA.
  - Drop EX: 0xB. Drop MEM: 0xC. Drop WB: 0xD.
  - With rs1 = x0 and all three bypasses naming rd 0: id_rs1_data = 0.
- Load-use: EX holds lw x5 (ex_is_load = 1) and ID holds add x6,x5,x5.
  - Cycle 1: if_ready = 0, id_valid = 0.
  - Cycle 2, with mem_rd = 5 and mem_result = 0x1234: if_ready = 1, id_rs1_data = id_rs2_data = 0x1234.
  - If ID holds lui x6 instead: no stall.
- Immediates: sw x2,-4(x1) (0xFE20AE23) gives id_imm = 0xFFFFFFFC and id_is_store = 1. beq with offset -8 gives 0xFFFFFFF8. jal x1,+2048 gives 0x00000800. lui x1,0x12345 gives 0x12345000.
- Backpressure and flush: with ex_ready = 0 for 3 cycles, the ID/EX outputs are stable and if_ready = 0. Assert flush together with a load-use hazard: id_valid = 0 next cycle and if_ready = 1 in the flush cycle.
- Reset mid-stream: assert reset while id_valid = 1 and ex_ready = 0. Next cycle id_valid = 0 and all outputs are 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage: opcodes, immediate formats
// and the layout of the ID/EX pipeline register.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1Data;
        logic [XLEN-1:0] rs2Data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            regWrite;
        logic            isLoad;
        logic            isStore;
    } idex_t;

endpackage

// File: rtl/id_stage_if.sv
// Bundle of all decode-stage signals: IF/ID input, register-file ports,
// bypass sources, flush/backpressure and the ID/EX outputs.
interface id_stage_if;
    import riscv_pkg::*;

    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            if_ready;
    logic [4:0]      rf_read_addr_1;
    logic [4:0]      rf_read_addr_2;
    logic [XLEN-1:0] rf_read_data_1;
    logic [XLEN-1:0] rf_read_data_2;
    logic            ex_reg_write;
    logic            ex_is_load;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            mem_reg_write;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_result;
    logic            wb_reg_write;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            ex_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic [4:0]      id_rd;
    logic [6:0]      id_opcode;
    logic [2:0]      id_funct3;
    logic            id_funct7b5;
    logic            id_reg_write;
    logic            id_is_load;
    logic            id_is_store;

    modport slave (
        input  if_valid, if_instr, if_pc,
        output if_ready,
        output rf_read_addr_1, rf_read_addr_2,
        input  rf_read_data_1, rf_read_data_2,
        input  ex_reg_write, ex_is_load, ex_rd, ex_result,
        input  mem_reg_write, mem_rd, mem_result,
        input  wb_reg_write, wb_rd, wb_data,
        input  flush, ex_ready,
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        output id_rd, id_opcode, id_funct3, id_funct7b5,
        output id_reg_write, id_is_load, id_is_store
    );

    modport master (
        output if_valid, if_instr, if_pc,
        input  if_ready,
        input  rf_read_addr_1, rf_read_addr_2,
        output rf_read_data_1, rf_read_data_2,
        output ex_reg_write, ex_is_load, ex_rd, ex_result,
        output mem_reg_write, mem_rd, mem_result,
        output wb_reg_write, wb_rd, wb_data,
        output flush, ex_ready,
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
        input  id_rd, id_opcode, id_funct3, id_funct7b5,
        input  id_reg_write, id_is_load, id_is_store
    );

endinterface

// File: rtl/id_stage_imm_gen.sv
// RV32I immediate generator: rearranges and sign-extends the immediate bits
// of an instruction according to its format.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_fmt_t    fmt_i,
    output logic [31:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (fmt_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the IF/ID instruction, resolves operands through
// the EX/MEM/WB bypasses, stalls on load-use and registers results in ID/EX.
module id_stage #(
    parameter int XLEN = 32
) (
    input logic       clk,
    input logic       reset,
    id_stage_if.slave bus
);
    import riscv_pkg::*;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            usesRs1;
    logic            usesRs2;
    logic            regWrite;
    logic            isLoad;
    logic            isStore;
    imm_fmt_t        immFmt;
    logic [31:0]     imm;
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic            hazard;
    idex_t           idex_d;
    idex_t           idex_q;

    assign opcode = bus.if_instr[6:0];
    assign rd     = bus.if_instr[11:7];
    assign rs1    = bus.if_instr[19:15];
    assign rs2    = bus.if_instr[24:20];

    assign bus.rf_read_addr_1 = rs1;
    assign bus.rf_read_addr_2 = rs2;

    always_comb begin
        usesRs1  = 1'b0;
        usesRs2  = 1'b0;
        regWrite = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        immFmt   = IMM_NONE;
        case (opcode)
            OP_LUI, OP_AUIPC: begin
                regWrite = 1'b1;
                immFmt   = IMM_U;
            end
            OP_JAL: begin
                regWrite = 1'b1;
                immFmt   = IMM_J;
            end
            OP_JALR, OP_IMM: begin
                usesRs1  = 1'b1;
                regWrite = 1'b1;
                immFmt   = IMM_I;
            end
            OP_LOAD: begin
                usesRs1  = 1'b1;
                regWrite = 1'b1;
                isLoad   = 1'b1;
                immFmt   = IMM_I;
            end
            OP_BRANCH: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                immFmt  = IMM_B;
            end
            OP_STORE: begin
                usesRs1 = 1'b1;
                usesRs2 = 1'b1;
                isStore = 1'b1;
                immFmt  = IMM_S;
            end
            OP_REG: begin
                usesRs1  = 1'b1;
                usesRs2  = 1'b1;
                regWrite = 1'b1;
            end
            default: ;
        endcase
        if (rd == 5'd0) regWrite = 1'b0;
    end

    imm_gen u_imm_gen (
        .instr_i (bus.if_instr[31:7]),
        .fmt_i   (immFmt),
        .imm_o   (imm)
    );

    // Loads in EX have no data yet, so they are excluded from the EX bypass;
    // the load-use stall covers that case instead.
    function automatic logic [XLEN-1:0] selectOperand(input logic [4:0] rs,
                                                      input logic [XLEN-1:0] rfData);
        if (rs == 5'd0)
            return '0;
        else if (bus.ex_reg_write && !bus.ex_is_load && bus.ex_rd == rs)
            return bus.ex_result;
        else if (bus.mem_reg_write && bus.mem_rd == rs)
            return bus.mem_result;
        else if (bus.wb_reg_write && bus.wb_rd == rs)
            return bus.wb_data;
        else
            return rfData;
    endfunction

    assign operand1 = selectOperand(rs1, bus.rf_read_data_1);
    assign operand2 = selectOperand(rs2, bus.rf_read_data_2);

    assign hazard = bus.if_valid && bus.ex_is_load && bus.ex_reg_write &&
                    (bus.ex_rd != 5'd0) &&
                    ((usesRs1 && bus.ex_rd == rs1) || (usesRs2 && bus.ex_rd == rs2));

    assign bus.if_ready = bus.flush || (bus.ex_ready && !hazard);

    // Flush beats backpressure beats the load-use bubble; payload fields are
    // left untouched whenever valid drops since downstream ignores them.
    always_comb begin
        idex_d = idex_q;
        if (bus.flush) begin
            idex_d.valid = 1'b0;
        end else if (bus.ex_ready) begin
            if (hazard) begin
                idex_d.valid    = 1'b0;
                idex_d.regWrite = 1'b0;
                idex_d.isLoad   = 1'b0;
                idex_d.isStore  = 1'b0;
            end else begin
                idex_d.valid    = bus.if_valid;
                idex_d.pc       = bus.if_pc;
                idex_d.rs1Data  = operand1;
                idex_d.rs2Data  = operand2;
                idex_d.imm      = imm;
                idex_d.rd       = rd;
                idex_d.opcode   = opcode;
                idex_d.funct3   = bus.if_instr[14:12];
                idex_d.funct7b5 = bus.if_instr[30];
                idex_d.regWrite = regWrite;
                idex_d.isLoad   = isLoad;
                idex_d.isStore  = isStore;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) idex_q <= '0;
        else       idex_q <= idex_d;
    end

    assign bus.id_valid     = idex_q.valid;
    assign bus.id_pc        = idex_q.pc;
    assign bus.id_rs1_data  = idex_q.rs1Data;
    assign bus.id_rs2_data  = idex_q.rs2Data;
    assign bus.id_imm       = idex_q.imm;
    assign bus.id_rd        = idex_q.rd;
    assign bus.id_opcode    = idex_q.opcode;
    assign bus.id_funct3    = idex_q.funct3;
    assign bus.id_funct7b5  = idex_q.funct7b5;
    assign bus.id_reg_write = idex_q.regWrite;
    assign bus.id_is_load   = idex_q.isLoad;
    assign bus.id_is_store  = idex_q.isStore;

endmodule
